// File: rtl/vga_capture_pkg.sv
// Shared timing defaults, checker state encoding and CRC constants for the VGA capture block.
package vga_capture_pkg;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_START  = 144;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_V_START  = 35;
  localparam int DEF_V_ACTIVE = 480;
  localparam bit DEF_SYNC_POL = 1'b0;

  // Internal counter width; leaves headroom above H_TOTAL for the saturated runaway value.
  localparam int CW = 12;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_crc16.sv
// Running CRC-16-CCITT over 12-bit pixels, MSB first; only built when VGA_CAPTURE_CRC_EN is defined.
module vga_crc16
  import vga_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [11:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_next;
  logic        fb;

  always_comb begin
    crc_next = crc;
    fb       = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      fb       = crc_next[15] ^ data[i];
      crc_next = {crc_next[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates, checks sync timing and reports per-frame status.
// Optional frame CRC enabled by defining VGA_CAPTURE_CRC_EN.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_START  = DEF_H_START,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_START  = DEF_V_START,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc
);

  localparam logic [CW-1:0] HT   = CW'(H_TOTAL);
  localparam logic [CW-1:0] HSY  = CW'(H_SYNC);
  localparam logic [CW-1:0] HST  = CW'(H_START);
  localparam logic [CW-1:0] HEND = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] VT   = CW'(V_TOTAL);
  localparam logic [CW-1:0] VST  = CW'(V_START);
  localparam logic [CW-1:0] VEND = CW'(V_START + V_ACTIVE);

  state_t        state;
  logic          hs_prev, vs_prev, armed;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          hs_a, vs_a, hs_edge, hs_deassert, vs_edge;
  logic [CW-1:0] h_inc, h_now, v_now;
  logic          viol, active, capture, frame_ok;

  // h_cnt/v_cnt hold the coordinate of the previous tick; h_now/v_now are this tick's.
  always_comb begin
    hs_a        = (VGA_HS == SYNC_POL);
    vs_a        = (VGA_VS == SYNC_POL);
    hs_edge     = hs_a && !hs_prev;
    hs_deassert = !hs_a && hs_prev;
    vs_edge     = vs_a && !vs_prev;
    h_inc       = h_cnt + CW'(1);
    h_now       = hs_edge ? '0 : ((h_cnt == HT) ? HT : h_inc);
    v_now       = v_cnt;
    if (hs_edge) begin
      v_now = (armed || vs_edge) ? '0 : v_cnt + CW'(1);
    end
    viol = (state != SEARCH) &&
           ((hs_edge && (h_inc != HT)) ||
            (!hs_edge && (h_inc == HT)) ||
            (hs_deassert && (h_inc != HSY)) ||
            (vs_edge && (v_cnt + CW'(1) != VT)));
    active   = (h_now >= HST) && (h_now < HEND) && (v_now >= VST) && (v_now < VEND);
    capture  = (state == LOCKED) && !viol && active;
    frame_ok = (state == LOCKED) && vs_edge && !viol;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      armed      <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      timing_err <= 1'b0;
      err_cnt    <= '0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      if (pix_en) begin
        hs_prev <= hs_a;
        vs_prev <= vs_a;
        h_cnt   <= h_now;
        v_cnt   <= v_now;
        if (hs_edge) begin
          armed <= 1'b0;
        end else if (vs_edge) begin
          armed <= 1'b1;
        end
        if (capture) begin
          pix_valid <= 1'b1;
          pix_x     <= 10'(h_now - HST);
          pix_y     <= 10'(v_now - VST);
          pix_rgb   <= {VGA_R, VGA_G, VGA_B};
        end
        // A violation always wins over the VS-driven state advance on the same tick.
        if (viol) begin
          state      <= SEARCH;
          timing_err <= 1'b1;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end else if (vs_edge) begin
          case (state)
            SEARCH:  state <= TRACK;
            TRACK:   state <= LOCKED;
            default: begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end
          endcase
        end
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_run;

  vga_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (pix_en && vs_edge),
    .en   (pix_en && capture),
    .data ({VGA_R, VGA_G, VGA_B}),
    .crc  (crc_run)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_crc <= '0;
    end else if (pix_en && frame_ok) begin
      frame_crc <= crc_run;
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
